// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-requester data memory arbiter.
//   state_e  - controller phase (zero-fill pass, then normal arbitration)
//   req_id_e - requester identity, also the round-robin pointer encoding
//   req_t    - request payload as presented by a requester
//   rsp_t    - bookkeeping for the single in-flight response
package dmem_arb_pkg;

    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam int unsigned DATA_W        = 64;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic    valid;
        req_id_e owner;
        logic    read;
        logic    err;
    } rsp_t;

endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: combinational 2-way round-robin picker.
//   valid[1:0] - request present (bit 0 = A, bit 1 = B)
//   ptr        - requester favoured when both are valid
//   grant[1:0] - one-hot grant (or zero when nothing is valid)
//   next_ptr   - pointer after this cycle: the loser of a grant, else ptr
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_e    ptr,
    output logic [1:0] grant,
    output req_id_e    next_ptr
);

    // Contention goes to ptr; a lone requester always wins.
    always_comb begin
        grant    = 2'b00;
        next_ptr = ptr;
        if (valid == 2'b11) begin
            grant = (ptr == REQ_A) ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
        if (grant[0]) begin
            next_ptr = REQ_B;
        end else if (grant[1]) begin
            next_ptr = REQ_A;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: zero-fills a single-port data memory after reset, then shares it
// round-robin between requester A (load/store unit) and requester B (debug/DMA).
// Each accepted request gets exactly one response pulse one cycle later.
//   clk, rst_n                  - clock, synchronous active-low reset
//   a_req_* / b_req_*           - valid/ready request channels (write, addr, wdata)
//   a_rsp_* / b_rsp_*           - response pulse, read data, range error
//   mem_*                       - drive/return of the external registered-read memory
//   init_done                   - high once the zero-fill pass has completed
// Build option: define DMEM_ARB_RANGE_CHK_EN to flag addresses >= DEPTH as errors
// (no memory access, rsp_err=1); otherwise addresses wrap modulo DEPTH.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [DATA_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,
    output logic              a_rsp_err,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [DATA_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic              b_rsp_err,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              init_done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    req_id_e           rr_ptr_q, rr_next;
    logic [1:0]        grant;
    rsp_t              rsp_q, rsp_d;
    req_t              req_a, req_b, sel;
    logic              in_init;
    logic              sel_oob;

    assign req_a = {a_req_write, a_req_addr, a_req_wdata};
    assign req_b = {b_req_write, b_req_addr, b_req_wdata};

    // Reset held low behaves like INIT so no request can slip through mid-reset.
    assign in_init = !rst_n || (state_q == INIT);

    dmem_arb_rr u_rr (
        .valid    ({b_req_valid, a_req_valid} & {2{!in_init}}),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .next_ptr (rr_next)
    );

    assign sel = grant[1] ? req_b : req_a;

`ifdef DMEM_ARB_RANGE_CHK_EN
    assign sel_oob = (sel.addr >= 64'(DEPTH));
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |sel.addr[DATA_W-1:ADDR_W];
    assign sel_oob        = 1'b0;
`endif

    // Next state, memory drive, handshakes and the response to be registered.
    always_comb begin
        state_d       = state_q;
        mem_address   = '0;
        mem_data_in   = '0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        a_req_ready   = 1'b0;
        b_req_ready   = 1'b0;
        rsp_d.valid   = 1'b0;
        rsp_d.owner   = REQ_A;
        rsp_d.read    = 1'b0;
        rsp_d.err     = 1'b0;
        if (in_init) begin
            mem_write   = 1'b1;
            mem_address = DATA_W'(init_cnt_q);
            if ((state_q == INIT) && (init_cnt_q == ADDR_W'(DEPTH - 1))) begin
                state_d = RUN;
            end
        end else begin
            a_req_ready = grant[0];
            b_req_ready = grant[1];
            if (|grant) begin
                mem_address = DATA_W'(sel.addr[ADDR_W-1:0]);
                mem_data_in = sel.wdata;
                mem_write   = sel.write && !sel_oob;
                mem_read    = !sel.write && !sel_oob;
                rsp_d.valid = 1'b1;
                rsp_d.owner = grant[1] ? REQ_B : REQ_A;
                rsp_d.read  = !sel.write && !sel_oob;
                rsp_d.err   = sel_oob;
            end
        end
    end

    // State, fill counter, round-robin pointer and response pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            rr_ptr_q   <= REQ_A;
            rsp_q      <= '0;
            init_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            init_done <= (state_d == RUN);
            if (state_q == INIT) begin
                init_cnt_q <= (state_d == RUN) ? '0 : init_cnt_q + ADDR_W'(1);
            end
            if (|grant) begin
                rr_ptr_q <= rr_next;
            end
        end
    end

    // Read data comes straight from the memory's output register; gating with
    // rst_n drops a response that is in flight when reset asserts.
    assign a_rsp_valid = rst_n && rsp_q.valid && (rsp_q.owner == REQ_A);
    assign b_rsp_valid = rst_n && rsp_q.valid && (rsp_q.owner == REQ_B);
    assign a_rsp_rdata = (a_rsp_valid && rsp_q.read) ? mem_data_out : '0;
    assign b_rsp_rdata = (b_rsp_valid && rsp_q.read) ? mem_data_out : '0;
    assign a_rsp_err   = a_rsp_valid && rsp_q.err;
    assign b_rsp_err   = b_rsp_valid && rsp_q.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a 16-word memory.
// A reference model of arbitration, fill sequence and memory contents predicts
// every cycle; expected responses are queued at acceptance and compared when due.
module tb_dmem_arbiter;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] data;
    } req_s;

    typedef struct {
        int          cyc;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err;
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [63:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [63:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_write, mem_read, init_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    exp_t qa[$];
    exp_t qb[$];
    req_s sa[$];
    req_s sb[$];

    logic [63:0] mem     [DEPTH];
    logic [63:0] ref_mem [DEPTH];
    logic        mrun = 1'b0;
    int          mcnt = 0;
    logic        mptr = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_req_write  (a_req_write),
        .a_req_addr   (a_req_addr),
        .a_req_wdata  (a_req_wdata),
        .a_rsp_valid  (a_rsp_valid),
        .a_rsp_rdata  (a_rsp_rdata),
        .a_rsp_err    (a_rsp_err),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_req_write  (b_req_write),
        .b_req_addr   (b_req_addr),
        .b_req_wdata  (b_req_wdata),
        .b_rsp_valid  (b_rsp_valid),
        .b_rsp_rdata  (b_rsp_rdata),
        .b_rsp_err    (b_rsp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_data_out (mem_data_out),
        .init_done    (init_done)
    );

    // Single-port memory: write on clock, registered read, contents not reset.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[ADDR_W-1:0]] <= mem_data_in;
        if (mem_read)  mem_data_out <= mem[mem_address[ADDR_W-1:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model, evaluated mid-cycle on settled inputs/outputs.
    always @(negedge clk) begin : monitor
        logic        ga, gb, oob;
        req_s        r;
        exp_t        e;
        int unsigned idx;
        cyc++;
        if (!rst_n) begin
            chk("rst_a_rsp", 64'(a_rsp_valid), 64'd0);
            chk("rst_b_rsp", 64'(b_rsp_valid), 64'd0);
            chk("rst_ready", 64'({a_req_ready, b_req_ready}), 64'd0);
            qa.delete();
            qb.delete();
            mrun = 1'b0;
            mcnt = 0;
            mptr = 1'b0;
        end else begin
            if (qa.size() > 0 && qa[0].cyc == cyc) begin
                e = qa.pop_front();
                chk("a_rsp_valid", 64'(a_rsp_valid), 64'd1);
                chk("a_rsp_rdata", a_rsp_rdata, e.rdata);
                chk("a_rsp_err", 64'(a_rsp_err), 64'(e.err));
            end else begin
                chk("a_rsp_idle", 64'({a_rsp_valid, a_rsp_err, |a_rsp_rdata}), 64'd0);
            end
            if (qb.size() > 0 && qb[0].cyc == cyc) begin
                e = qb.pop_front();
                chk("b_rsp_valid", 64'(b_rsp_valid), 64'd1);
                chk("b_rsp_rdata", b_rsp_rdata, e.rdata);
                chk("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
            end else begin
                chk("b_rsp_idle", 64'({b_rsp_valid, b_rsp_err, |b_rsp_rdata}), 64'd0);
            end
            chk("init_done", 64'(init_done), 64'(mrun));
            if (!mrun) begin
                chk("init_ready", 64'({a_req_ready, b_req_ready}), 64'd0);
                chk("init_rw", 64'({mem_write, mem_read}), 64'd2);
                chk("init_addr", mem_address, 64'(mcnt));
                chk("init_data", mem_data_in, 64'd0);
                ref_mem[mcnt] = 64'd0;
                if (mcnt == int'(DEPTH) - 1) begin
                    mrun = 1'b1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end else begin
                ga = a_req_valid && (!b_req_valid || !mptr);
                gb = b_req_valid && !ga;
                chk("a_ready", 64'(a_req_ready), 64'(ga));
                chk("b_ready", 64'(b_req_ready), 64'(gb));
                if (ga || gb) begin
                    r = ga ? {a_req_write, a_req_addr, a_req_wdata}
                           : {b_req_write, b_req_addr, b_req_wdata};
                    mptr = ga;
`ifdef DMEM_ARB_RANGE_CHK_EN
                    oob = (r.addr >= 64'(DEPTH));
`else
                    oob = 1'b0;
`endif
                    idx = 32'(r.addr % 64'(DEPTH));
                    if (oob) begin
                        chk("oob_mem_rw", 64'({mem_write, mem_read}), 64'd0);
                        e.rdata = 64'd0;
                        e.err   = 1'b1;
                    end else begin
                        chk("mem_addr", mem_address, 64'(idx));
                        chk("mem_rw", 64'({mem_write, mem_read}), 64'({r.write, !r.write}));
                        e.err = 1'b0;
                        if (r.write) begin
                            chk("mem_wdata", mem_data_in, r.data);
                            ref_mem[idx] = r.data;
                            e.rdata      = 64'd0;
                        end else begin
                            e.rdata = ref_mem[idx];
                        end
                    end
                    e.cyc = cyc + 1;
                    if (ga) qa.push_back(e);
                    else    qb.push_back(e);
                end else begin
                    chk("idle_mem", 64'({mem_write, mem_read, |mem_address}), 64'd0);
                end
            end
        end
    end

    function automatic req_s mk(input logic w, input logic [63:0] addr, input logic [63:0] data);
        req_s r;
        r.write = w;
        r.addr  = addr;
        r.data  = data;
        return r;
    endfunction

    // Present the request queues, keeping each valid asserted until accepted.
    task automatic pump(input int budget);
        int  n = 0;
        logic acc_a, acc_b;
        while ((sa.size() > 0 || sb.size() > 0) && n < budget) begin
            a_req_valid = (sa.size() > 0);
            if (sa.size() > 0) {a_req_write, a_req_addr, a_req_wdata} = sa[0];
            b_req_valid = (sb.size() > 0);
            if (sb.size() > 0) {b_req_write, b_req_addr, b_req_wdata} = sb[0];
            @(negedge clk);
            acc_a = a_req_valid && a_req_ready;
            acc_b = b_req_valid && b_req_ready;
            @(posedge clk);
            #1;
            if (acc_a) void'(sa.pop_front());
            if (acc_b) void'(sb.pop_front());
            n++;
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        chk("pump_drained", 64'(sa.size() + sb.size()), 64'd0);
        sa.delete();
        sb.delete();
    endtask

    // Called just after reset release; zero-fill must take exactly DEPTH cycles.
    task automatic wait_init();
        int n = 0;
        forever begin
            @(negedge clk);
            if (init_done === 1'b1) break;
            n++;
            if (n > int'(DEPTH) + 10) break;
        end
        chk("init_len", 64'(n), 64'(DEPTH));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();

        // Contending reads straight after reset: order A,B,A,B; all words zeroed.
        sa.push_back(mk(1'b0, 64'd1, 64'd0)); sa.push_back(mk(1'b0, 64'd2, 64'd0));
        sb.push_back(mk(1'b0, 64'd8, 64'd0)); sb.push_back(mk(1'b0, 64'd9, 64'd0));
        pump(20);

        // Contending writes, then cross reads of each other's data.
        sa.push_back(mk(1'b1, 64'd3, 64'hA5A5_0000_0000_0003));
        sa.push_back(mk(1'b1, 64'd4, 64'hA5A5_0000_0000_0004));
        sb.push_back(mk(1'b1, 64'd9, 64'h5A5A_0000_0000_0009));
        pump(20);
        sa.push_back(mk(1'b0, 64'd3, 64'd0)); sa.push_back(mk(1'b0, 64'd9, 64'd0));
        sb.push_back(mk(1'b0, 64'd4, 64'd0)); sb.push_back(mk(1'b0, 64'd3, 64'd0));
        pump(20);

        // Back-to-back write then read of the same word.
        sa.push_back(mk(1'b1, 64'd5, 64'h0000_0000_DEAD_BEEF));
        sa.push_back(mk(1'b0, 64'd5, 64'd0));
        pump(20);
        sb.push_back(mk(1'b0, 64'd5, 64'd0)); sb.push_back(mk(1'b0, 64'd5, 64'd0));
        pump(20);

        // Out-of-range addresses (error, or wrap onto word 0 when unchecked).
        sa.push_back(mk(1'b1, 64'd0, 64'h0123_4567_89AB_CDEF));
        pump(20);
        sb.push_back(mk(1'b0, 64'd1024, 64'd0));
        sb.push_back(mk(1'b0, 64'(DEPTH), 64'd0));
        sb.push_back(mk(1'b1, 64'(DEPTH) + 64'd2, 64'h1111_2222_3333_4444));
        sb.push_back(mk(1'b0, 64'd2, 64'd0));
        pump(20);

        // Random mixed traffic on both ports.
        for (int i = 0; i < 60; i++) begin
            sa.push_back(mk(1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 64'(DEPTH + $urandom_range(0, 40))
                                                         : 64'($urandom_range(0, DEPTH - 1)),
                            {$urandom, $urandom}));
            sb.push_back(mk(1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 64'(DEPTH + $urandom_range(0, 40))
                                                         : 64'($urandom_range(0, DEPTH - 1)),
                            {$urandom, $urandom}));
        end
        pump(400);

        // Reset right after a granted read: response dropped, memory re-zeroed.
        sa.push_back(mk(1'b1, 64'd7, 64'h7777_7777_7777_7777));
        sa.push_back(mk(1'b0, 64'd7, 64'd0));
        pump(20);
        a_req_write = 1'b0; a_req_addr = 64'd7; a_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_pre_grant", 64'(a_req_ready), 64'd1);
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init();
        sa.push_back(mk(1'b0, 64'd7, 64'd0));
        sb.push_back(mk(1'b0, 64'd0, 64'd0));
        pump(20);

        repeat (3) @(posedge clk);
        #1;
        chk("a_rsp_outstanding", 64'(qa.size()), 64'd0);
        chk("b_rsp_outstanding", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
